// File: rtl/sram_2p_march_bist_ctrl_if.sv
// sram_2p_march_bist_ctrl_if: BIST pin bundle between the march controller and one SRAM port.
// master = controller side, slave = macro/test-harness side.
interface sram_2p_march_bist_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              START;
    logic [DATA_W-1:0] BIST_DOUT;
    logic              BIST_EN;
    logic              BIST_MEN;
    logic              BIST_WEN;
    logic              BIST_REN;
    logic [ADDR_W-1:0] BIST_ADDR;
    logic [DATA_W-1:0] BIST_DIN;
    logic [DATA_W-1:0] BIST_BM;
    logic              BUSY;
    logic              DONE;
    logic              FAIL;
    logic [ADDR_W-1:0] FAIL_ADDR;
    logic [2:0]        FAIL_ELEM;
    logic [DATA_W-1:0] FAIL_DATA;
    modport master (
        input  START, BIST_DOUT,
        output BIST_EN, BIST_MEN, BIST_WEN, BIST_REN, BIST_ADDR, BIST_DIN, BIST_BM,
        output BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_DATA
    );
    modport slave (
        output START, BIST_DOUT,
        input  BIST_EN, BIST_MEN, BIST_WEN, BIST_REN, BIST_ADDR, BIST_DIN, BIST_BM,
        input  BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_DATA
    );
endinterface

// File: rtl/sram_2p_march_bist_ctrl.sv
// sram_2p_march_bist_ctrl: March C- BIST sequencer for one port of the 512x32 two-port SRAM.
// Issues one op per cycle, compares reads RD_LAT cycles later, records the first miscompare.
module sram_2p_march_bist_ctrl #(
    parameter int                ADDR_W = 9,
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] BG     = '0,
    parameter int                RD_LAT = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    sram_2p_march_bist_ctrl_if.master bif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, END} state_t;
    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] exp;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        elem;
    } cmp_t;
    localparam logic [ADDR_W-1:0] TOP = '1;
    localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT - 1);
    state_t            r_state, w_state_nxt;
    logic [2:0]        r_elem, w_elem_nxt, r_drain, r_fail_elem;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt, r_fail_addr;
    logic              r_op, w_op_nxt;
    logic              w_two, w_desc, w_elem_done, w_go, w_run_nxt, w_rd_nxt;
    logic              r_busy, r_men, r_wen, r_ren, r_done, r_fail;
    logic [DATA_W-1:0] r_din, r_fail_data;
    cmp_t              r_pipe [RD_LAT];
    cmp_t              w_tap;

    assign w_tap = r_pipe[RD_LAT-1];

    always_ff @(posedge CLK) r_state <= RST ? IDLE : w_state_nxt;

    // r_elem/r_addr/r_op always describe the command currently on the pins
    always_comb begin
        w_two = r_elem != 3'd0 && r_elem != 3'd5;
        w_desc = r_elem == 3'd3 || r_elem == 3'd4;
        w_elem_done = (!w_two || r_op) && r_addr == (w_desc ? '0 : TOP);
        w_go = bif.START && (r_state == IDLE || r_state == END);
        w_state_nxt = r_state;
        w_elem_nxt = r_elem;
        w_addr_nxt = r_addr;
        w_op_nxt = r_op;
        if (w_go) begin
            w_state_nxt = RUN;
            w_elem_nxt = '0;
            w_addr_nxt = '0;
            w_op_nxt = 1'b0;
        end else if (r_state == RUN) begin
            if (w_elem_done && r_elem == 3'd5) w_state_nxt = DRAIN;
            else begin
                w_op_nxt = w_two && !r_op;
                w_elem_nxt = r_elem + {2'b0, w_elem_done};
                w_addr_nxt = w_op_nxt ? r_addr
                           : !w_elem_done ? (w_desc ? r_addr - 1'b1 : r_addr + 1'b1)
                           : (r_elem == 3'd2 || r_elem == 3'd3) ? TOP : '0;
            end
        end else if (r_state == DRAIN && r_drain == DRAIN_LAST) w_state_nxt = END;
        w_run_nxt = w_state_nxt == RUN;
        w_rd_nxt = w_run_nxt && w_elem_nxt != 3'd0 && !w_op_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_elem <= '0;
            r_addr <= '0;
            r_op <= 1'b0;
            r_drain <= '0;
            r_busy <= 1'b0;
            r_men <= 1'b0;
            r_wen <= 1'b0;
            r_ren <= 1'b0;
            r_done <= 1'b0;
            r_fail <= 1'b0;
            r_din <= '0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_data <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_elem <= w_elem_nxt;
            r_addr <= w_addr_nxt;
            r_op <= w_op_nxt;
            r_drain <= r_state == DRAIN ? r_drain + 3'd1 : 3'd0;
            r_busy <= w_run_nxt || w_state_nxt == DRAIN;
            r_done <= w_state_nxt == END;
            r_men <= w_run_nxt;
            r_ren <= w_rd_nxt;
            r_wen <= w_run_nxt && !w_rd_nxt;
            if (w_run_nxt && !w_rd_nxt) r_din <= w_elem_nxt[0] ? ~BG : BG;
            r_pipe[0] <= '{v: w_rd_nxt, exp: (w_elem_nxt == 3'd2 || w_elem_nxt == 3'd4) ? ~BG : BG,
                           addr: w_addr_nxt, elem: w_elem_nxt};
            for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
            if (w_go) begin
                r_fail <= 1'b0;
                r_fail_addr <= '0;
                r_fail_elem <= '0;
                r_fail_data <= '0;
            end else if (w_tap.v && bif.BIST_DOUT != w_tap.exp && !r_fail) begin
                r_fail <= 1'b1;
                r_fail_addr <= w_tap.addr;
                r_fail_elem <= w_tap.elem;
                r_fail_data <= bif.BIST_DOUT;
            end
        end
    end

    assign bif.BIST_EN   = r_busy;
    assign bif.BUSY      = r_busy;
    assign bif.BIST_MEN  = r_men;
    assign bif.BIST_WEN  = r_wen;
    assign bif.BIST_REN  = r_ren;
    assign bif.BIST_ADDR = r_addr;
    assign bif.BIST_DIN  = r_din;
    assign bif.BIST_BM   = '1;
    assign bif.DONE      = r_done;
    assign bif.FAIL      = r_fail;
    assign bif.FAIL_ADDR = r_fail_addr;
    assign bif.FAIL_ELEM = r_fail_elem;
    assign bif.FAIL_DATA = r_fail_data;
endmodule

// File: tb/tb_sram_2p_march_bist_ctrl.sv
// tb_sram_2p_march_bist_ctrl: drives the BIST controller against a behavioural SRAM with
// injectable stuck-at bits and checks it against a march-table reference model.
module tb_sram_2p_march_bist_ctrl;
    localparam int AW = 9, DW = 32, N = 1 << AW, LAT = 2;
    localparam logic [DW-1:0] BG = '0;
    typedef struct packed {
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;
    logic clk = 1'b0, rst = 1'b1;
    int checks = 0, errors = 0;
    logic [DW-1:0] mem [N];
    logic [DW-1:0] sa0 [N];
    logic [DW-1:0] sa1 [N];
    op_t got [$];
    int busy_cyc = 0, onehot_err = 0;
    bit mon = 1'b0;

    sram_2p_march_bist_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();
    sram_2p_march_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BG(BG), .RD_LAT(LAT)) dut (
        .CLK(clk), .RST(rst), .bif(bif));

    always #5 clk = ~clk;

    // macro: samples the command one edge after it is registered, read data valid one cycle later
    always @(posedge clk) begin
        if (bif.BIST_MEN && bif.BIST_WEN) mem[bif.BIST_ADDR] <= bif.BIST_DIN;
        if (bif.BIST_MEN && bif.BIST_REN)
            bif.BIST_DOUT <= (mem[bif.BIST_ADDR] & ~sa0[bif.BIST_ADDR]) | sa1[bif.BIST_ADDR];
    end

    always @(negedge clk) if (mon) begin
        if (bif.BUSY) busy_cyc++;
        if (bif.BIST_MEN) begin
            if (bif.BIST_WEN == bif.BIST_REN) onehot_err++;
            got.push_back({bif.BIST_WEN, bif.BIST_ADDR, bif.BIST_DIN});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // March C-: E0 u(w0) E1 u(r0,w1) E2 u(r1,w0) E3 d(r0,w1) E4 d(r1,w0) E5 u(r0)
    function automatic bit has_rd(int e); return e != 0; endfunction
    function automatic bit has_wr(int e); return e != 5; endfunction
    function automatic logic [DW-1:0] rd_val(int e); return (e == 2 || e == 4) ? ~BG : BG; endfunction
    function automatic logic [DW-1:0] wr_val(int e); return (e == 1 || e == 3) ? ~BG : BG; endfunction
    function automatic int addr_of(int e, int j); return (e == 3 || e == 4) ? N - 1 - j : j; endfunction

    task automatic ref_march(output bit f, output logic [AW-1:0] fa, output logic [2:0] fe,
                             output logic [DW-1:0] fd);
        logic [DW-1:0] m [N];
        logic [DW-1:0] v;
        int a;
        f = 1'b0; fa = '0; fe = '0; fd = '0;
        for (int e = 0; e < 6; e++)
            for (int j = 0; j < N; j++) begin
                a = addr_of(e, j);
                if (has_rd(e)) begin
                    v = (m[a] & ~sa0[a]) | sa1[a];
                    if (!f && v !== rd_val(e)) begin
                        f = 1'b1; fa = AW'(a); fe = 3'(e); fd = v;
                    end
                end
                if (has_wr(e)) m[a] = wr_val(e);
            end
    endtask

    task automatic check_stream(input string tag);
        int k = 0, bad = 0, nw = 0, nr = 0, a;
        for (int e = 0; e < 6; e++)
            for (int j = 0; j < N; j++) begin
                a = addr_of(e, j);
                if (has_rd(e)) begin
                    if (k >= got.size() || got[k].wr || got[k].a != AW'(a)) bad++;
                    k++;
                end
                if (has_wr(e)) begin
                    if (k >= got.size() || !got[k].wr || got[k].a != AW'(a) || got[k].d != wr_val(e)) bad++;
                    k++;
                end
            end
        foreach (got[i]) if (got[i].wr) nw++; else nr++;
        chk({tag, "_ops"}, got.size(), 10 * N);
        chk({tag, "_writes"}, nw, 5 * N);
        chk({tag, "_reads"}, nr, 5 * N);
        chk({tag, "_seq_bad"}, bad, 0);
        chk({tag, "_onehot"}, onehot_err, 0);
        if (got.size() == 10 * N) begin
            chk({tag, "_first"}, got[0], {1'b1, AW'(0), BG});
            chk({tag, "_e3_start"}, {got[5*N].wr, got[5*N].a}, {1'b0, AW'(N - 1)});
            chk({tag, "_last"}, {got[10*N-1].wr, got[10*N-1].a}, {1'b0, AW'(N - 1)});
        end
    endtask

    task automatic run_march(input string tag, input int noise_at);
        bit rf;
        logic [AW-1:0] ra;
        logic [2:0] re;
        logic [DW-1:0] rd;
        int c;
        ref_march(rf, ra, re, rd);
        repeat ($urandom_range(1, 6)) @(negedge clk);
        got.delete(); busy_cyc = 0; onehot_err = 0; mon = 1'b1;
        bif.START = 1'b1;
        @(negedge clk);
        bif.START = 1'b0;
        chk({tag, "_start_flags"}, {bif.BUSY, bif.BIST_EN, bif.DONE, bif.FAIL}, 4'b1100);
        for (c = 0; c < 12000 && !bif.DONE; c++) begin
            bif.START = (c == noise_at);
            @(negedge clk);
        end
        bif.START = 1'b0;
        mon = 1'b0;
        chk({tag, "_no_timeout"}, c < 12000, 1);
        chk({tag, "_busy_cycles"}, busy_cyc, 10 * N + LAT);
        chk({tag, "_end_flags"}, {bif.DONE, bif.BUSY, bif.BIST_EN, bif.BIST_MEN}, 4'b1000);
        chk({tag, "_fail"}, bif.FAIL, rf);
        if (rf) begin
            chk({tag, "_fail_addr"}, bif.FAIL_ADDR, ra);
            chk({tag, "_fail_elem"}, bif.FAIL_ELEM, re);
            chk({tag, "_fail_data"}, bif.FAIL_DATA, rd);
        end
        check_stream(tag);
    endtask

    task automatic clear_faults();
        foreach (sa0[i]) begin
            sa0[i] = '0;
            sa1[i] = '0;
        end
    endtask

    initial begin
        int c, na, nb;
        clear_faults();
        bif.START = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {bif.BUSY, bif.DONE, bif.FAIL, bif.BIST_EN, bif.BIST_MEN, bif.BIST_WEN, bif.BIST_REN}, 7'b0);
        chk("rst_bus", {bif.BIST_ADDR, bif.BIST_DIN}, '0);
        chk("rst_fail_fields", {bif.FAIL_ADDR, bif.FAIL_ELEM, bif.FAIL_DATA}, '0);
        chk("rst_bm", bif.BIST_BM, {DW{1'b1}});
        bif.START = 1'b1;
        @(negedge clk);
        bif.START = 1'b0;
        rst = 1'b0;
        chk("rst_beats_start", {bif.BUSY, bif.BIST_MEN}, 2'b00);
        @(negedge clk);
        chk("rst_beats_start_hold", {bif.BUSY, bif.BIST_MEN}, 2'b00);

        run_march("clean", $urandom_range(20, 5000));

        clear_faults();
        sa1['h0A5][3] = 1'b1;
        run_march("sa1", $urandom_range(20, 5000));
        chk("sa1_dir", {bif.FAIL, bif.FAIL_ELEM, bif.FAIL_ADDR, bif.FAIL_DATA}, {1'b1, 3'd1, 9'h0A5, 32'h8});

        clear_faults();
        sa0['h010][0] = 1'b1;
        sa0['h020][0] = 1'b1;
        run_march("two", $urandom_range(20, 5000));
        chk("two_dir", {bif.FAIL, bif.FAIL_ELEM, bif.FAIL_ADDR, bif.FAIL_DATA}, {1'b1, 3'd2, 9'h010, 32'hFFFF_FFFE});

        for (int it = 0; it < 2; it++) begin
            clear_faults();
            repeat ($urandom_range(1, 3)) begin
                na = $urandom_range(0, N - 1);
                nb = $urandom_range(0, DW - 1);
                if ($urandom_range(0, 1) == 1) sa1[na][nb] = 1'b1; else sa0[na][nb] = 1'b1;
            end
            run_march($sformatf("rnd%0d", it), $urandom_range(20, 5000));
        end

        clear_faults();
        sa0['h100][5] = 1'b1;
        got.delete(); mon = 1'b1;
        bif.START = 1'b1;
        @(negedge clk);
        bif.START = 1'b0;
        for (c = 0; c < 2000 && got.size() < N + 100; c++) @(negedge clk);
        mon = 1'b0;
        chk("mid_reach_e1", c < 2000, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_flags", {bif.BUSY, bif.BIST_MEN, bif.BIST_EN, bif.BIST_WEN, bif.BIST_REN, bif.DONE, bif.FAIL}, 7'b0);
        repeat (4) @(negedge clk);
        chk("mid_rst_idle", {bif.BUSY, bif.BIST_MEN, bif.FAIL}, 3'b0);
        clear_faults();
        run_march("rerun", $urandom_range(20, 5000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_2p_march_bist_ctrl.md
Name: sram_2p_march_bist_ctrl

Overview:
- March C- self-test sequencer for one port (A or B) of the 512x32 two-port SRAM macro with byte mask and BIST mux.
- Drives the macro's *_BIST_* pins and BIST_EN, compares read data against expected values, and reports pass or first failure.
- Instantiated once per port beside the macro. The macro's BIST_CLK is tied to CLK.

Parameters:
- ADDR_W, 9, address width; depth N = 2**ADDR_W.
- DATA_W, 32, data width.
- BG, 32'h0000_0000, data background; "0" = BG, "1" = ~BG.
- RD_LAT, 2, cycles from a registered read command to the edge where DOUT is sampled. Legal values are 1..4.

Ports:
- CLK  in  1  clock; all flops rising edge.
- RST  in  1  synchronous reset, active-high.
- START  in  1  one-cycle pulse; begins a test. Ignored unless idle.
- BIST_DOUT  in  DATA_W  macro DOUT for this port.
- BIST_EN  out  1  macro BIST mux select.
- BIST_MEN  out  1  macro enable.
- BIST_WEN  out  1  write strobe.
- BIST_REN  out  1  read strobe.
- BIST_ADDR  out  ADDR_W  address.
- BIST_DIN  out  DATA_W  write data.
- BIST_BM  out  DATA_W  bit mask; all ones while BIST_EN=1.
- BUSY  out  1  test in progress.
- DONE  out  1  sticky; test finished.
- FAIL  out  1  sticky; a miscompare occurred.
- FAIL_ADDR  out  ADDR_W  address of the first miscompare.
- FAIL_ELEM  out  3  march element (0..5) of the first miscompare.
- FAIL_DATA  out  DATA_W  DOUT captured at the first miscompare.

Behaviour:
- Reset values: every output is 0, except BIST_BM, which is all ones. The FSM is in IDLE.
- All outputs are registered. A command registered at edge k is sampled by the macro at edge k+1. The matching read data is compared at edge k+RD_LAT.
- FSM states: IDLE, RUN, DRAIN, END.
- IDLE -> RUN on START.
  - Clears DONE, FAIL and the FAIL_* fields.
  - Sets BUSY=1 and BIST_EN=1.
  - Sets elem=0, addr=0, op=0.
- March elements ("u" = ascending address, "d" = descending address):
  - E0 u(w0)
  - E1 u(r0,w1)
  - E2 u(r1,w0)
  - E3 d(r0,w1)
  - E4 d(r1,w0)
  - E5 u(r0)
- One operation per cycle. Each RUN cycle has MEN=1 and exactly one of WEN/REN=1.
- Two-op elements issue r then w on the same address in consecutive cycles, then advance the address.
- Descending elements start at N-1 and end at 0. Ascending elements run 0 to N-1. The address never wraps inside an element.
- At the last op of the last address of an element, elem increments and addr is loaded with the new element's start value. There are no idle cycles between elements.
- The RUN phase lasts exactly 10N cycles (5120 for N=512).
- After the last op of E5: enter DRAIN and set MEN=WEN=REN=0.
- DRAIN lasts RD_LAT cycles so that outstanding reads are compared. Then enter END.
- END: DONE=1, BUSY=0, BIST_EN=0. Stay in END until the next START.
  - START in END behaves as from IDLE.
  - The FSM returns to IDLE only on RST.
- Compare pipeline:
  - Depth RD_LAT shift register carrying {valid, expected, addr, elem} for each read.
  - At the tap: if valid and BIST_DOUT != expected, and FAIL=0, then set FAIL=1 and capture FAIL_ADDR, FAIL_ELEM and FAIL_DATA.
  - Later miscompares are ignored. The test still runs to completion.
- Write data: BIST_DIN = BG for w0, ~BG for w1. During reads, BIST_DIN holds its last value.
- RST mid-test: next cycle all outputs are at reset values, the pipeline is flushed, and no write is issued.
- START while BUSY=1 is ignored.
- RST has priority over START when both are asserted in the same cycle.

Test Plan:
- Fault-free model, RD_LAT=2, START pulse -> BUSY high for exactly 10*512+2 cycles. Then DONE=1, FAIL=0, BIST_EN=0.
- Monitor the command stream -> first op is w addr 0 with DIN 0x00000000. The E3 start is r addr 0x1FF. The last op is r addr 0x1FF. There are exactly 2560 writes and 2560 reads.
- Model with addr 0x0A5 bit 3 stuck-at-1 -> FAIL=1, FAIL_ELEM=1, FAIL_ADDR=0x0A5, FAIL_DATA=0x00000008. DONE is still asserted at the end.
- Two faults (0x010 stuck-at-0 on bit 0, then 0x020) -> FAIL_ADDR=0x010, FAIL_ELEM=2, FAIL_DATA=0xFFFFFFFE. The second fault is not recorded.
- RST asserted 100 cycles into E1 -> next cycle BUSY=0, MEN=0, BIST_EN=0. A new START reruns cleanly with FAIL=0.
- START pulses during RUN and again after DONE -> the RUN-phase START is ignored (cycle count unchanged). The post-DONE START clears DONE and reruns.
